batalla_turn_ctrl: RTL and testbench
====================================

# batalla_turn_ctrl

Game sequencer for the 5x5 naval-battle design. It owns both board arrays and the cursor that the VGA block renders. It arbitrates shots between the human player (debounced button pulses) and the PC shot generator (valid/ack handshake), and it decides hit/miss, turn order, turn timeout and the winner. All outputs feed `vga` directly: `i_actual`, `j_actual`, `tablero_jugador` and `tablero_pc`.

## Interface
- `TURN_CYCLES`, default 50_000_000: length of the player turn in `clk` cycles before auto-fire.
- `SHIP_CELLS`, default 5: ship cells per board. Reaching this hit count wins.
- `clk` in 1: system clock. All logic is single-domain on `clk`.
- `rst_n` in 1: reset, synchronous, active-low.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_fire` in 1 each: one-cycle button pulses, already debounced.
- `start` in 1: one-cycle pulse that begins a game, or leaves GAME_OVER.
- `clr` in 1: in IDLE only, clears both boards to 0 (water).
- `ld_valid` in 1: in IDLE only, writes a board cell.
- `ld_board` in 1: load target, 0 = `tablero_jugador`, 1 = `tablero_pc`.
- `ld_i`, `ld_j` in 3 each: cell row and column for the load.
- `ld_val` in 2: value written by the load.
- `pc_req` in 1: PC shot request. Held high until `pc_ack`.
- `pc_i`, `pc_j` in 3 each: target of the PC shot. Must stay stable while `pc_req` is high.
- `pc_ack` out 1: one-cycle acknowledge of a PC request.
- `pc_retry` out 1: qualifies `pc_ack`. 1 = shot rejected, 0 = shot accepted.
- `pc_hit` out 1: qualifies `pc_ack`. 1 = hit, 0 = miss.
- `i_actual`, `j_actual` out 3 each: cursor row and column, range 0..4.
- `tablero_jugador`, `tablero_pc` out 2x[5][5]: registered board arrays.
- `turn` out 1: 0 = player, 1 = PC.
- `game_over` out 1: high while in GAME_OVER.
- `winner` out 1: meaningful only when `game_over` = 1. 0 = player, 1 = PC.

## Operation
- Cell encoding: 0 = water, 1 = ship, 2 = hit, 3 = miss.
  - A cell is *unshot* when its value is below 2.
  - Shooting an unshot cell: 1 becomes 2 and counts as a hit; 0 becomes 3 and counts as a miss.
- States: IDLE, P_TURN, P_RES, PC_TURN, PC_RES, GAME_OVER.
- IDLE:
  - `clr` has priority over `ld_valid` in the same cycle.
  - `ld_valid` writes `ld_val` to the addressed cell. A load with `ld_i` > 4 or `ld_j` > 4 is ignored.
  - `start` does the following, then moves to P_TURN:
    - zeroes both hit counters;
    - sets the cursor to (0,0);
    - loads the timer with TURN_CYCLES-1.
- P_TURN, cursor movement:
  - Up/down step `i_actual`; left/right step `j_actual`.
  - Each step is ±1 and wraps 4↔0.
  - Opposite pulses in the same cycle cancel.
- P_TURN, firing:
  - `btn_fire` targets the cursor value as it was *before* any move in that same cycle.
  - Firing on an unshot `tablero_pc` cell updates the cell, adds to `hits_p` on a hit, and moves to P_RES.
  - Firing on an already-shot cell is ignored; the state stays P_TURN and the timer keeps running.
- P_TURN, timeout:
  - The timer decrements every cycle.
  - If it is 0 and there is no fire, the block auto-fires at the cursor.
  - If that cell is already shot, the turn is forfeited and the state goes to PC_TURN.
- P_RES: if `hits_p` == SHIP_CELLS, go to GAME_OVER with `winner` = 0; otherwise go to PC_TURN.
- PC_TURN, on `pc_req`:
  - The block samples `pc_i`, `pc_j` and goes to PC_RES.
  - PC_RES pulses `pc_ack`.
  - Target out of range (> 4) or already shot: `pc_retry` = 1, `tablero_jugador` is unchanged, and the state returns to PC_TURN.
  - Otherwise: `tablero_jugador` is updated and `pc_hit` reports hit or miss.
  - On an accepted shot: if `hits_pc` == SHIP_CELLS, go to GAME_OVER with `winner` = 1; otherwise reload the timer and go to P_TURN.
  - PC_TURN has no timeout.
- GAME_OVER:
  - Boards are frozen and all button, load and PC inputs are ignored.
  - `start` returns to IDLE; the boards are kept.
- Outside IDLE, `clr` and `ld_valid` are ignored.
- Hit counters are 3 bits wide and never exceed SHIP_CELLS.

## Timing
- Reset values: state IDLE, both boards all 0, cursor (0,0), `turn` = 0, `game_over` = 0, `winner` = 0, `pc_ack` = 0, `pc_retry` = 0, `pc_hit` = 0, timer = TURN_CYCLES-1, hit counters = 0.
- `rst_n` low in any state, including mid-handshake, restores all reset values at the next edge. No `pc_ack` is issued for the pending request.
- All outputs are registered.
- A cursor move is visible 1 cycle after the button pulse.
- Player fire at edge t: the board cell updates at t+1 (state P_RES); `turn` = 1 or `game_over` = 1 at t+2.
- PC shot: with `pc_req` first high at edge t, `pc_ack`, `pc_retry` and `pc_hit` are high for exactly the cycle after t+1.
  - The board update is visible in that same cycle.
  - After a retry, `pc_req` may stay high; the next ack comes 2 cycles later.
- `turn` changes in the same cycle as the corresponding state change.
- `pc_req` is ignored outside PC_TURN.

## Test plan
- Reset, then move the cursor: 4×`btn_up` → `i_actual` = 1 (0→4→3→2→1); `btn_left` and `btn_right` in the same cycle → `j_actual` unchanged.
- Load a ship at PC board (2,3), `start`, move the cursor to (2,3), fire → `tablero_pc[2][3]` = 2 at t+1, `turn` = 1 at t+2. Fire again at the same cell in a later player turn → ignored, state stays P_TURN.
- PC turn: `pc_req` at (5,0) → `pc_ack` with `pc_retry` = 1. Then (1,1) holding water → `pc_ack` with `pc_retry` = 0, `pc_hit` = 0, `tablero_jugador[1][1]` = 3, `turn` = 0.
- TURN_CYCLES = 8, no fire: auto-fire at the cursor on the 8th cycle; if the cell is already shot → forfeit, `turn` = 1, boards unchanged.
- SHIP_CELLS = 1: player hits the only ship → `game_over` = 1, `winner` = 0. Later button, `ld_valid` and `pc_req` inputs → no change. `start` → IDLE with boards kept.
- `rst_n` low for 1 cycle while `pc_req` is pending in PC_RES → no `pc_ack`; state IDLE, boards 0, cursor (0,0).

Source files
------------

// File: rtl/batalla_turn_ctrl_if.sv
// PC shot handshake between the shot generator (master) and the turn controller (slave).
// The master holds pc_req and a stable target until it sees a one-cycle pc_ack.
interface batalla_turn_ctrl_if;
  logic       pc_req;
  logic [2:0] pc_i;
  logic [2:0] pc_j;
  logic       pc_ack;
  logic       pc_retry;
  logic       pc_hit;

  modport master (
    output pc_req, pc_i, pc_j,
    input  pc_ack, pc_retry, pc_hit
  );

  modport slave (
    input  pc_req, pc_i, pc_j,
    output pc_ack, pc_retry, pc_hit
  );
endinterface

// File: rtl/batalla_turn_ctrl.sv
// Naval-battle game sequencer: owns both 5x5 boards and the cursor, arbitrates player and
// PC shots, enforces the player turn timeout and decides the winner.
module batalla_turn_ctrl #(
  parameter int TURN_CYCLES = 50_000_000,
  parameter int SHIP_CELLS  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_fire,
  input  logic                 start,
  input  logic                 clr,
  input  logic                 ld_valid,
  input  logic                 ld_board,
  input  logic [2:0]           ld_i,
  input  logic [2:0]           ld_j,
  input  logic [1:0]           ld_val,
  batalla_turn_ctrl_if.slave   pc,
  output logic [2:0]           i_actual,
  output logic [2:0]           j_actual,
  output logic [1:0]           tablero_jugador [5][5],
  output logic [1:0]           tablero_pc [5][5],
  output logic                 turn,
  output logic                 game_over,
  output logic                 winner
);

  localparam int             TW         = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TW-1:0]  TIMER_LOAD = TW'(TURN_CYCLES - 1);
  localparam logic [2:0]     SHIP_N     = 3'(SHIP_CELLS);

  typedef enum logic [2:0] {
    IDLE, P_TURN, P_RES, PC_TURN, PC_RES, GAME_OVER
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [2:0]      hits_p;
  logic [2:0]      hits_pc;
  logic [2:0]      pc_i_q;
  logic [2:0]      pc_j_q;

  logic [2:0]      i_mv;
  logic [2:0]      j_mv;
  logic [1:0]      p_cell;
  logic            p_unshot;
  logic            timer_zero;
  logic            pc_oob;
  logic [1:0]      pc_cell;
  logic            pc_unshot;
  logic [2:0]      hits_pc_nxt;

  function automatic logic [2:0] step_inc(input logic [2:0] v);
    return (v == 3'd4) ? 3'd0 : v + 3'd1;
  endfunction

  function automatic logic [2:0] step_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd4 : v - 3'd1;
  endfunction

  // Ship cells become hits, water becomes a miss.
  function automatic logic [1:0] shoot(input logic [1:0] c);
    return (c == 2'd1) ? 2'd2 : 2'd3;
  endfunction

  always_comb begin
    i_mv = i_actual;
    j_mv = j_actual;
    if (btn_up && !btn_down)         i_mv = step_dec(i_actual);
    else if (btn_down && !btn_up)    i_mv = step_inc(i_actual);
    if (btn_left && !btn_right)      j_mv = step_dec(j_actual);
    else if (btn_right && !btn_left) j_mv = step_inc(j_actual);
  end

  always_comb begin
    p_cell      = tablero_pc[i_actual][j_actual];
    p_unshot    = (p_cell < 2'd2);
    timer_zero  = (timer == '0);
    pc_oob      = (pc_i_q > 3'd4) || (pc_j_q > 3'd4);
    pc_cell     = pc_oob ? 2'd0 : tablero_jugador[pc_i_q][pc_j_q];
    pc_unshot   = (pc_cell < 2'd2);
    hits_pc_nxt = hits_pc + ((pc_cell == 2'd1) ? 3'd1 : 3'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= TIMER_LOAD;
      hits_p      <= 3'd0;
      hits_pc     <= 3'd0;
      i_actual    <= 3'd0;
      j_actual    <= 3'd0;
      turn        <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
      pc.pc_ack   <= 1'b0;
      pc.pc_retry <= 1'b0;
      pc.pc_hit   <= 1'b0;
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          tablero_jugador[r][c] <= 2'd0;
          tablero_pc[r][c]      <= 2'd0;
        end
      end
    end else begin
      pc.pc_ack   <= 1'b0;
      pc.pc_retry <= 1'b0;
      pc.pc_hit   <= 1'b0;
      case (state)
        IDLE: begin
          if (clr) begin
            for (int r = 0; r < 5; r++) begin
              for (int c = 0; c < 5; c++) begin
                tablero_jugador[r][c] <= 2'd0;
                tablero_pc[r][c]      <= 2'd0;
              end
            end
          end else if (ld_valid && (ld_i <= 3'd4) && (ld_j <= 3'd4)) begin
            if (ld_board) tablero_pc[ld_i][ld_j]      <= ld_val;
            else          tablero_jugador[ld_i][ld_j] <= ld_val;
          end
          if (start) begin
            hits_p   <= 3'd0;
            hits_pc  <= 3'd0;
            i_actual <= 3'd0;
            j_actual <= 3'd0;
            timer    <= TIMER_LOAD;
            turn     <= 1'b0;
            state    <= P_TURN;
          end
        end
        P_TURN: begin
          i_actual <= i_mv;
          j_actual <= j_mv;
          // Fire and auto-fire both target the cursor as it stood before this cycle's move.
          if ((btn_fire || timer_zero) && p_unshot) begin
            tablero_pc[i_actual][j_actual] <= shoot(p_cell);
            if (p_cell == 2'd1) hits_p <= hits_p + 3'd1;
            state <= P_RES;
          end else if (timer_zero) begin
            turn  <= 1'b1;
            state <= PC_TURN;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        P_RES: begin
          if (hits_p == SHIP_N) begin
            game_over <= 1'b1;
            winner    <= 1'b0;
            state     <= GAME_OVER;
          end else begin
            turn  <= 1'b1;
            state <= PC_TURN;
          end
        end
        PC_TURN: begin
          if (pc.pc_req) begin
            pc_i_q <= pc.pc_i;
            pc_j_q <= pc.pc_j;
            state  <= PC_RES;
          end
        end
        PC_RES: begin
          pc.pc_ack <= 1'b1;
          if (pc_oob || !pc_unshot) begin
            pc.pc_retry <= 1'b1;
            state       <= PC_TURN;
          end else begin
            tablero_jugador[pc_i_q][pc_j_q] <= shoot(pc_cell);
            pc.pc_hit <= (pc_cell == 2'd1);
            hits_pc   <= hits_pc_nxt;
            if (hits_pc_nxt == SHIP_N) begin
              game_over <= 1'b1;
              winner    <= 1'b1;
              state     <= GAME_OVER;
            end else begin
              timer <= TIMER_LOAD;
              turn  <= 1'b0;
              state <= P_TURN;
            end
          end
        end
        GAME_OVER: begin
          if (start) begin
            game_over <= 1'b0;
            turn      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_batalla_turn_ctrl.sv
// Directed bench: unit A (long turn, 5 ships) covers cursor, shots and handshake;
// unit B (8-cycle turn, 1 ship) covers timeout, forfeit and game over.
module tb_batalla_turn_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_fire = 0;
  logic       start = 0, clr = 0, ld_valid = 0, ld_board = 0;
  logic [2:0] ld_i = 0, ld_j = 0;
  logic [1:0] ld_val = 0;
  logic [2:0] a_i, a_j;
  logic [1:0] a_tj [5][5];
  logic [1:0] a_tp [5][5];
  logic       a_turn, a_go, a_win;

  logic       b_btn_up = 0, b_btn_down = 0, b_btn_left = 0, b_btn_right = 0, b_btn_fire = 0;
  logic       b_start = 0, b_clr = 0, b_ld_valid = 0, b_ld_board = 0;
  logic [2:0] b_ld_i = 0, b_ld_j = 0;
  logic [1:0] b_ld_val = 0;
  logic [2:0] b_i, b_j;
  logic [1:0] b_tj [5][5];
  logic [1:0] b_tp [5][5];
  logic       b_turn, b_go, b_win;

  batalla_turn_ctrl_if a_pc();
  batalla_turn_ctrl_if b_pc();

  int tests = 0;
  int fails = 0;

  batalla_turn_ctrl #(.TURN_CYCLES(1000), .SHIP_CELLS(5)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_fire(btn_fire), .start(start), .clr(clr), .ld_valid(ld_valid), .ld_board(ld_board),
    .ld_i(ld_i), .ld_j(ld_j), .ld_val(ld_val), .pc(a_pc),
    .i_actual(a_i), .j_actual(a_j), .tablero_jugador(a_tj), .tablero_pc(a_tp),
    .turn(a_turn), .game_over(a_go), .winner(a_win)
  );

  batalla_turn_ctrl #(.TURN_CYCLES(8), .SHIP_CELLS(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .btn_up(b_btn_up), .btn_down(b_btn_down), .btn_left(b_btn_left), .btn_right(b_btn_right),
    .btn_fire(b_btn_fire), .start(b_start), .clr(b_clr), .ld_valid(b_ld_valid),
    .ld_board(b_ld_board), .ld_i(b_ld_i), .ld_j(b_ld_j), .ld_val(b_ld_val), .pc(b_pc),
    .i_actual(b_i), .j_actual(b_j), .tablero_jugador(b_tj), .tablero_pc(b_tp),
    .turn(b_turn), .game_over(b_go), .winner(b_win)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tests++; if (a_i !== 3'd0 || a_j !== 3'd0) begin fails++; $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", a_i, a_j); end
    tests++; if (a_turn !== 1'b0) begin fails++; $display("FAIL reset_turn: got %b want 0", a_turn); end
    tests++; if (a_go !== 1'b0 || a_win !== 1'b0) begin fails++; $display("FAIL reset_go_win: got %b%b want 00", a_go, a_win); end
    tests++; if ({a_pc.pc_ack, a_pc.pc_retry, a_pc.pc_hit} !== 3'b000) begin fails++; $display("FAIL reset_pc_out: got %b want 000", {a_pc.pc_ack, a_pc.pc_retry, a_pc.pc_hit}); end
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        tests++; if (a_tj[r][c] !== 2'd0 || a_tp[r][c] !== 2'd0) begin fails++; $display("FAIL reset_board[%0d][%0d]: got %0d/%0d want 0/0", r, c, a_tj[r][c], a_tp[r][c]); end
      end
    end
  endtask

  task automatic test_cursor();
    int n;
    ld_valid = 1; ld_board = 1; ld_i = 0; ld_j = 0; ld_val = 1;
    tick();
    tests++; if (a_tp[0][0] !== 2'd1) begin fails++; $display("FAIL load_cell: got %0d want 1", a_tp[0][0]); end
    clr = 1; ld_i = 4; ld_j = 4;
    tick();
    clr = 0;
    tests++; if (a_tp[0][0] !== 2'd0 || a_tp[4][4] !== 2'd0) begin fails++; $display("FAIL clr_priority: got %0d/%0d want 0/0", a_tp[0][0], a_tp[4][4]); end
    ld_i = 5; ld_j = 0;
    tick();
    ld_i = 2; ld_j = 3;
    tick();
    ld_valid = 0;
    n = 0;
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) if (a_tp[r][c] != 2'd0) n++;
    tests++; if (n != 1 || a_tp[2][3] !== 2'd1) begin fails++; $display("FAIL load_oob: got %0d nonzero, cell=%0d want 1, 1", n, a_tp[2][3]); end
    start = 1;
    tick();
    start = 0;
    tests++; if (a_turn !== 1'b0 || a_go !== 1'b0) begin fails++; $display("FAIL start: got turn=%b go=%b want 0 0", a_turn, a_go); end
    btn_up = 1;
    tick();
    tests++; if (a_i !== 3'd4) begin fails++; $display("FAIL up_wrap: got %0d want 4", a_i); end
    tick(); tick(); tick();
    btn_up = 0;
    tests++; if (a_i !== 3'd1) begin fails++; $display("FAIL up_x4: got %0d want 1", a_i); end
    btn_left = 1; btn_right = 1;
    tick();
    btn_left = 0; btn_right = 0;
    tests++; if (a_j !== 3'd0) begin fails++; $display("FAIL lr_cancel: got %0d want 0", a_j); end
    btn_down = 1;
    tick();
    btn_down = 0; btn_right = 1;
    tick(); tick(); tick();
    btn_right = 0;
    tests++; if (a_i !== 3'd2 || a_j !== 3'd3) begin fails++; $display("FAIL cursor_2_3: got (%0d,%0d) want (2,3)", a_i, a_j); end
  endtask

  task automatic test_player_fire();
    btn_fire = 1;
    tick();
    btn_fire = 0;
    tests++; if (a_tp[2][3] !== 2'd2 || a_turn !== 1'b0) begin fails++; $display("FAIL fire_t1: got cell=%0d turn=%b want 2 0", a_tp[2][3], a_turn); end
    tick();
    tests++; if (a_turn !== 1'b1 || a_go !== 1'b0) begin fails++; $display("FAIL fire_t2: got turn=%b go=%b want 1 0", a_turn, a_go); end
  endtask

  task automatic test_pc_turn();
    a_pc.pc_i = 5; a_pc.pc_j = 0; a_pc.pc_req = 1;
    tick();
    tests++; if (a_pc.pc_ack !== 1'b0) begin fails++; $display("FAIL pc_ack_early: got %b want 0", a_pc.pc_ack); end
    tick();
    tests++; if (a_pc.pc_ack !== 1'b1 || a_pc.pc_retry !== 1'b1) begin fails++; $display("FAIL pc_retry1: got ack=%b retry=%b want 1 1", a_pc.pc_ack, a_pc.pc_retry); end
    tick();
    tests++; if (a_pc.pc_ack !== 1'b0) begin fails++; $display("FAIL pc_ack_pulse: got %b want 0", a_pc.pc_ack); end
    tick();
    tests++; if (a_pc.pc_ack !== 1'b1 || a_pc.pc_retry !== 1'b1) begin fails++; $display("FAIL pc_retry2: got ack=%b retry=%b want 1 1", a_pc.pc_ack, a_pc.pc_retry); end
    a_pc.pc_req = 0;
    tick();
    tests++; if (a_pc.pc_ack !== 1'b0 || a_turn !== 1'b1) begin fails++; $display("FAIL pc_idle: got ack=%b turn=%b want 0 1", a_pc.pc_ack, a_turn); end
    a_pc.pc_i = 1; a_pc.pc_j = 1; a_pc.pc_req = 1;
    tick();
    tick();
    tests++; if ({a_pc.pc_ack, a_pc.pc_retry, a_pc.pc_hit} !== 3'b100) begin fails++; $display("FAIL pc_miss: got ack/retry/hit=%b want 100", {a_pc.pc_ack, a_pc.pc_retry, a_pc.pc_hit}); end
    tests++; if (a_tj[1][1] !== 2'd3 || a_turn !== 1'b0) begin fails++; $display("FAIL pc_miss_board: got cell=%0d turn=%b want 3 0", a_tj[1][1], a_turn); end
    a_pc.pc_req = 0;
    tick();
    tests++; if (a_pc.pc_ack !== 1'b0) begin fails++; $display("FAIL pc_ack_drop: got %b want 0", a_pc.pc_ack); end
  endtask

  task automatic test_refire();
    btn_fire = 1;
    tick();
    btn_fire = 0;
    tick();
    tests++; if (a_turn !== 1'b0 || a_tp[2][3] !== 2'd2) begin fails++; $display("FAIL refire_ignored: got turn=%b cell=%0d want 0 2", a_turn, a_tp[2][3]); end
    btn_down = 1;
    tick();
    btn_down = 0; btn_fire = 1;
    tick();
    btn_fire = 0;
    tests++; if (a_tp[3][3] !== 2'd3) begin fails++; $display("FAIL fire_water: got %0d want 3", a_tp[3][3]); end
    tick();
    tests++; if (a_turn !== 1'b1) begin fails++; $display("FAIL fire_water_turn: got %b want 1", a_turn); end
  endtask

  task automatic test_reset_mid_handshake();
    a_pc.pc_i = 0; a_pc.pc_j = 0; a_pc.pc_req = 1;
    tick();
    rst_n = 0;
    tick();
    rst_n = 1; a_pc.pc_req = 0;
    tests++; if (a_pc.pc_ack !== 1'b0 || a_turn !== 1'b0) begin fails++; $display("FAIL rst_mid_ack: got ack=%b turn=%b want 0 0", a_pc.pc_ack, a_turn); end
    tests++; if (a_i !== 3'd0 || a_j !== 3'd0) begin fails++; $display("FAIL rst_mid_cursor: got (%0d,%0d) want (0,0)", a_i, a_j); end
    tests++; if (a_tp[2][3] !== 2'd0 || a_tp[3][3] !== 2'd0 || a_tj[1][1] !== 2'd0) begin fails++; $display("FAIL rst_mid_boards: got %0d/%0d/%0d want 0/0/0", a_tp[2][3], a_tp[3][3], a_tj[1][1]); end
    tick();
    tests++; if (a_pc.pc_ack !== 1'b0) begin fails++; $display("FAIL rst_mid_late_ack: got %b want 0", a_pc.pc_ack); end
    ld_valid = 1; ld_board = 0; ld_i = 4; ld_j = 4; ld_val = 2;
    tick();
    ld_valid = 0;
    tests++; if (a_tj[4][4] !== 2'd2) begin fails++; $display("FAIL rst_mid_idle_load: got %0d want 2", a_tj[4][4]); end
  endtask

  task automatic test_timeout();
    b_ld_valid = 1; b_ld_board = 1; b_ld_i = 0; b_ld_j = 0; b_ld_val = 3;
    tick();
    b_ld_i = 1; b_ld_j = 0; b_ld_val = 1;
    tick();
    b_ld_valid = 0; b_start = 1;
    tick();
    b_start = 0;
    repeat (7) tick();
    tests++; if (b_turn !== 1'b0) begin fails++; $display("FAIL timeout_early: got turn=%b want 0", b_turn); end
    tick();
    tests++; if (b_turn !== 1'b1 || b_tp[0][0] !== 2'd3 || b_tp[1][0] !== 2'd1) begin fails++; $display("FAIL forfeit: got turn=%b cells=%0d/%0d want 1 3/1", b_turn, b_tp[0][0], b_tp[1][0]); end
    b_pc.pc_i = 4; b_pc.pc_j = 4; b_pc.pc_req = 1;
    tick();
    tick();
    tests++; if (b_pc.pc_ack !== 1'b1 || b_pc.pc_retry !== 1'b0 || b_tj[4][4] !== 2'd3 || b_turn !== 1'b0) begin fails++; $display("FAIL b_pc_shot: got ack=%b retry=%b cell=%0d turn=%b want 1 0 3 0", b_pc.pc_ack, b_pc.pc_retry, b_tj[4][4], b_turn); end
    b_pc.pc_req = 0; b_btn_right = 1;
    tick();
    b_btn_right = 0;
    repeat (6) tick();
    tests++; if (b_tp[0][1] !== 2'd0 || b_j !== 3'd1) begin fails++; $display("FAIL autofire_early: got cell=%0d j=%0d want 0 1", b_tp[0][1], b_j); end
    tick();
    tests++; if (b_tp[0][1] !== 2'd3 || b_turn !== 1'b0) begin fails++; $display("FAIL autofire: got cell=%0d turn=%b want 3 0", b_tp[0][1], b_turn); end
    tick();
    tests++; if (b_turn !== 1'b1) begin fails++; $display("FAIL autofire_turn: got %b want 1", b_turn); end
  endtask

  task automatic test_game_over();
    b_pc.pc_i = 4; b_pc.pc_j = 3; b_pc.pc_req = 1;
    tick();
    tick();
    b_pc.pc_req = 0;
    tests++; if (b_pc.pc_ack !== 1'b1 || b_turn !== 1'b0) begin fails++; $display("FAIL b_pc_shot2: got ack=%b turn=%b want 1 0", b_pc.pc_ack, b_turn); end
    b_btn_down = 1; b_btn_left = 1;
    tick();
    b_btn_down = 0; b_btn_left = 0; b_btn_fire = 1;
    tick();
    b_btn_fire = 0;
    tests++; if (b_tp[1][0] !== 2'd2 || b_go !== 1'b0) begin fails++; $display("FAIL win_hit: got cell=%0d go=%b want 2 0", b_tp[1][0], b_go); end
    tick();
    tests++; if (b_go !== 1'b1 || b_win !== 1'b0) begin fails++; $display("FAIL win_player: got go=%b winner=%b want 1 0", b_go, b_win); end
    b_btn_up = 1;
    tick();
    b_btn_up = 0;
    tests++; if (b_i !== 3'd1) begin fails++; $display("FAIL go_btn_ignored: got i=%0d want 1", b_i); end
    b_ld_valid = 1; b_ld_board = 1; b_ld_i = 4; b_ld_j = 4; b_ld_val = 1;
    tick();
    b_ld_valid = 0;
    tests++; if (b_tp[4][4] !== 2'd0) begin fails++; $display("FAIL go_ld_ignored: got %0d want 0", b_tp[4][4]); end
    b_pc.pc_i = 2; b_pc.pc_j = 2; b_pc.pc_req = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (b_pc.pc_ack !== 1'b0) begin fails++; $display("FAIL go_pc_ignored: got ack=%b want 0", b_pc.pc_ack); end
    end
    b_pc.pc_req = 0;
    tests++; if (b_tj[2][2] !== 2'd0) begin fails++; $display("FAIL go_pc_board: got %0d want 0", b_tj[2][2]); end
    b_start = 1;
    tick();
    b_start = 0;
    tests++; if (b_go !== 1'b0 || b_tp[1][0] !== 2'd2 || b_tp[0][1] !== 2'd3) begin fails++; $display("FAIL go_restart: got go=%b cells=%0d/%0d want 0 2/3", b_go, b_tp[1][0], b_tp[0][1]); end
    b_ld_valid = 1; b_ld_board = 1; b_ld_i = 4; b_ld_j = 4; b_ld_val = 1;
    tick();
    b_ld_valid = 0;
    tests++; if (b_tp[4][4] !== 2'd1) begin fails++; $display("FAIL go_back_idle: got %0d want 1", b_tp[4][4]); end
  endtask

  initial begin
    a_pc.pc_req = 0; a_pc.pc_i = 0; a_pc.pc_j = 0;
    b_pc.pc_req = 0; b_pc.pc_i = 0; b_pc.pc_j = 0;
    test_reset();
    test_cursor();
    test_player_fire();
    test_pc_turn();
    test_refire();
    test_reset_mid_handshake();
    test_timeout();
    test_game_over();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
